// File: rtl/shift_arbiter_pkg.sv
// Shared types and helpers for the round-robin shift arbiter: op encoding,
// response-register states and a bit-reversal used to build right shifts.
package shift_pkg;

    localparam int SHIFT_W = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10
    } shift_op_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    function automatic logic [SHIFT_W-1:0] bit_reverse(input logic [SHIFT_W-1:0] x);
        logic [SHIFT_W-1:0] r;
        for (int i = 0; i < SHIFT_W; i++) begin
            r[i] = x[SHIFT_W-1-i];
        end
        return r;
    endfunction

    // Requester-index width; a single requester still gets a 1-bit id.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between execute-stage requesters (master) and the
// shared shifter arbiter (slave).
interface shift_arbiter_if
    import shift_pkg::*;
#(
    parameter int N    = SHIFT_W,
    parameter int NREQ = 2
) ();

    localparam int S   = $clog2(N);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ*S-1:0] req_shamt;
    logic [NREQ*2-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_data, req_shamt, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, req_shamt, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/shift_arbiter_core.sv
// SLL/SRL/SRA on a single left shifter: right shifts run on the bit-reversed
// operand, and SRA ORs in a sign-fill mask built from a shifted all-ones word.
module shift_core
    import shift_pkg::*;
#(
    parameter int N = SHIFT_W
) (
    input  logic [N-1:0]         i_in,
    input  logic [$clog2(N)-1:0] i_shamt,
    input  logic [1:0]           i_op,
    output logic [N-1:0]         o_out
);

    // N may be narrower than the package reversal width; reverse then take the top N bits.
    function automatic logic [N-1:0] rev_n(input logic [N-1:0] x);
        logic [SHIFT_W-1:0] t;
        t = bit_reverse(SHIFT_W'(x));
        return t[SHIFT_W-1 -: N];
    endfunction

    logic         w_right;
    logic         w_sign_fill;
    logic [N-1:0] w_sll_in;
    logic [N-1:0] w_sll_out;
    logic [N-1:0] w_ones_sll;
    logic [N-1:0] w_shifted;
    logic [N-1:0] w_mask;

    assign w_right     = (i_op == SHIFT_SRL) || (i_op == SHIFT_SRA);
    assign w_sign_fill = (i_op == SHIFT_SRA) && i_in[N-1];
    assign w_sll_in    = w_right ? rev_n(i_in) : i_in;

    sll #(.N(N)) u_sll_data (
        .i_data  (w_sll_in),
        .i_shamt (i_shamt),
        .o_data  (w_sll_out)
    );

    sll #(.N(N)) u_sll_mask (
        .i_data  ({N{1'b1}}),
        .i_shamt (i_shamt),
        .o_data  (w_ones_sll)
    );

    assign w_shifted = w_right ? rev_n(w_sll_out) : w_sll_out;
    assign w_mask    = w_sign_fill ? ~rev_n(w_ones_sll) : '0;
    assign o_out     = w_shifted | w_mask;

endmodule

// File: rtl/shift_arbiter_sll.sv
// Combinational logarithmic left shifter: one 2^k stage per shift-amount bit.
module sll #(
    parameter int N = 32
) (
    input  logic [N-1:0]         i_data,
    input  logic [$clog2(N)-1:0] i_shamt,
    output logic [N-1:0]         o_data
);

    localparam int S = $clog2(N);

    logic [N-1:0] w_stage [0:S];

    assign w_stage[0] = i_data;

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        assign w_stage[gi+1] = i_shamt[gi] ? (w_stage[gi] << (2 ** gi)) : w_stage[gi];
    end

    assign o_data = w_stage[S];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between NREQ requesters, with a
// single registered response slot that can be popped and refilled every cycle.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int N    = SHIFT_W,
    parameter int NREQ = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);

    localparam int S   = $clog2(N);
    localparam int IDW = id_width(NREQ);
    localparam int DW  = 2 * NREQ;
    localparam int PW  = $clog2(DW);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    rsp_state_t     r_state;
    logic [N-1:0]   r_rsp_data;
    logic [IDW-1:0] r_rsp_id;
    logic [IDW-1:0] r_ptr;

    rsp_state_t     w_state_next;
    logic [N-1:0]   w_data_next;
    logic [IDW-1:0] w_id_next;
    logic [IDW-1:0] w_ptr_next;

    logic [N-1:0]   w_data  [NREQ];
    logic [S-1:0]   w_shamt [NREQ];
    logic [1:0]     w_op    [NREQ];

    logic [DW-1:0]   w_dbl;
    logic [NREQ-1:0] w_window;
    logic            w_found;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW:0]    w_ptr_inc;
    logic [IDW-1:0]  w_grant_idx;
    logic            w_can_accept;
    logic            w_grant_en;
    logic [N-1:0]    w_shift_out;

    assign w_can_accept = (r_state == RSP_EMPTY) || bus.rsp_ready;
    assign w_dbl        = {bus.req_valid, bus.req_valid};

    // Window bit i is requester (ptr+i) mod NREQ, read from the doubled valid vector.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [PW-1:0] w_pos;

        assign w_data[gi]      = bus.req_data[gi*N +: N];
        assign w_shamt[gi]     = bus.req_shamt[gi*S +: S];
        assign w_op[gi]        = bus.req_op[gi*2 +: 2];
        assign w_pos           = PW'(r_ptr) + PW'(gi);
        assign w_window[gi]    = w_dbl[w_pos];
        assign bus.req_ready[gi] = w_grant_en && (w_grant_idx == IDW'(gi));
    end

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_window[i]) begin
                w_found = 1'b1;
                w_off   = IDW'(i);
            end
        end
    end

    always_comb begin
        w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
        w_grant_idx = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : IDW'(w_sum);
    end

    assign w_grant_en = rst_n && w_can_accept && w_found;
    assign w_ptr_inc  = {1'b0, w_grant_idx} + (IDW+1)'(1);

    shift_core #(.N(N)) u_core (
        .i_in    (w_data[w_grant_idx]),
        .i_shamt (w_shamt[w_grant_idx]),
        .i_op    (w_op[w_grant_idx]),
        .o_out   (w_shift_out)
    );

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_rsp_data;
        w_id_next    = r_rsp_id;
        w_ptr_next   = r_ptr;
        case (r_state)
            RSP_EMPTY: begin
                if (w_grant_en) begin
                    w_state_next = RSP_FULL;
                end
            end
            RSP_FULL: begin
                if (!w_grant_en && bus.rsp_ready) begin
                    w_state_next = RSP_EMPTY;
                end
            end
            default: w_state_next = RSP_EMPTY;
        endcase
        if (w_grant_en) begin
            w_data_next = w_shift_out;
            w_id_next   = w_grant_idx;
            w_ptr_next  = (w_ptr_inc == NREQ_W) ? '0 : IDW'(w_ptr_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RSP_EMPTY;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rsp_data <= w_data_next;
            r_rsp_id   <= w_id_next;
            r_ptr      <= w_ptr_next;
        end
    end

    assign bus.rsp_valid = (r_state == RSP_FULL);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scenario tasks for shift_arbiter plus a scoreboard monitor that checks the
// grant pattern and every consumed response against a shift reference model.
module tb_shift_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 2;
    localparam int S    = 5;
    localparam int IDW  = 1;

    typedef struct {
        logic [N-1:0]   data;
        logic [IDW-1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    shift_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int sh, input logic [1:0] op);
        case (op)
            2'b01:   return x >> sh;
            2'b10:   return N'($signed(x) >>> sh);
            default: return x << sh;
        endcase
    endfunction

    task automatic set_req(input int i, input logic v, input logic [N-1:0] d,
                           input logic [S-1:0] sh, input logic [1:0] op);
        bus.req_valid[i]         = v;
        bus.req_data[i*N +: N]   = d;
        bus.req_shamt[i*S +: S]  = sh;
        bus.req_op[i*2 +: 2]     = op;
    endtask

    // Scoreboard monitor: samples 1 time unit before each rising edge.
    initial begin : monitor
        int              m_ptr;
        int              idx;
        int              g;
        logic            can;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        m_ptr = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                n_checks++;
                if (bus.req_ready !== '0)
                    $display("FAIL mon_reset_ready: got %b want 0", bus.req_ready);
                else
                    n_pass++;
                m_ptr = 0;
            end else begin
                can     = !bus.rsp_valid || bus.rsp_ready;
                exp_rdy = '0;
                g       = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (can && bus.req_valid[idx] && g < 0) begin
                        exp_rdy[idx] = 1'b1;
                        g = idx;
                    end
                end
                n_checks++;
                if (bus.req_ready !== exp_rdy)
                    $display("FAIL mon_grant: req_ready=%b want %b (ptr=%0d valid=%b)",
                             bus.req_ready, exp_rdy, m_ptr, bus.req_valid);
                else
                    n_pass++;
                if (g >= 0) m_ptr = (g + 1) % NREQ;

                if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL mon_rsp_unexpected: data=%h id=%0d with empty scoreboard",
                                 bus.rsp_data, bus.rsp_id);
                    end else begin
                        e = sb_q.pop_front();
                        if (bus.rsp_data !== e.data || bus.rsp_id !== e.id)
                            $display("FAIL mon_rsp: data=%h id=%0d want data=%h id=%0d",
                                     bus.rsp_data, bus.rsp_id, e.data, e.id);
                        else
                            n_pass++;
                    end
                end

                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        e.data = ref_shift(bus.req_data[i*N +: N], int'(bus.req_shamt[i*S +: S]),
                                           bus.req_op[i*2 +: 2]);
                        e.id   = IDW'(i);
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h1234_5678, 5'd8, 2'b00);
        set_req(1, 1'b1, 32'hFFFF_0000, 5'd3, 2'b01);
        repeat (3) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0 ||
                bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0)
                $display("FAIL reset_state: ready=%b valid=%b data=%h id=%0d want 00/0/0/0",
                         bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
            else
                n_pass++;
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01)
            $display("FAIL reset_first_grant: req_ready=%b want 01", bus.req_ready);
        else
            n_pass++;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h3456_7800)
            $display("FAIL reset_first_rsp: valid=%b id=%0d data=%h want 1/0/34567800",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ops();
        logic [1:0]   op_tab [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [S-1:0] sh_tab [7] = '{5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4};
        logic [N-1:0] ex_tab [7] = '{32'h0000_0F00, 32'h0800_000F, 32'hF800_000F,
                                     32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                                     32'h0000_0F00};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            set_req(0, 1'b1, 32'h8000_00F0, sh_tab[k], op_tab[k]);
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ex_tab[k] || bus.rsp_id !== 1'b0)
                $display("FAIL ops_%0d: op=%b sh=%0d valid=%b data=%h id=%0d want data=%h id=0",
                         k, op_tab[k], sh_tab[k], bus.rsp_valid, bus.rsp_data, bus.rsp_id, ex_tab[k]);
            else
                n_pass++;
        end
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b1, 32'hA5A5_0000 + N'(k), S'(k), 2'(k % 3));
            set_req(1, 1'b1, 32'h8765_4321 + N'(k), S'(k + 3), 2'((k + 1) % 3));
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_checks++;
            if (bus.req_ready !== want)
                $display("FAIL rr_grant_%0d: req_ready=%b want %b", k, bus.req_ready, want);
            else
                n_pass++;
            if (k > 0) begin
                n_checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'((k - 1) % 2))
                    $display("FAIL rr_rsp_%0d: valid=%b id=%0d want 1/%0d",
                             k, bus.rsp_valid, bus.rsp_id, (k - 1) % 2);
                else
                    n_pass++;
            end
            @(negedge clk);
        end
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1)
            $display("FAIL rr_last_rsp: valid=%b id=%0d want 1/1", bus.rsp_valid, bus.rsp_id);
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a0 = 32'hC000_1234;
        logic [N-1:0] a1 = 32'h0F0F_8001;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, a0, 5'd7, 2'b10);
        set_req(1, 1'b1, a1, 5'd9, 2'b00);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01)
            $display("FAIL bp_first_grant: req_ready=%b want 01", bus.req_ready);
        else
            n_pass++;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        repeat (5) begin
            #1;
            n_checks++;
            if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b1 ||
                bus.rsp_data !== 32'hFF80_0024 || bus.rsp_id !== 1'b0)
                $display("FAIL bp_hold: ready=%b valid=%b data=%h id=%0d want 00/1/ff800024/0",
                         bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
            else
                n_pass++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10)
            $display("FAIL bp_resume_grant: req_ready=%b want 10", bus.req_ready);
        else
            n_pass++;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
        #1;
        n_checks++;
        if (bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'h1F00_0200)
            $display("FAIL bp_resume_rsp: data=%h id=%0d want 1f000200/1", bus.rsp_data, bus.rsp_id);
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h0000_00FF, 5'd1, 2'b00);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1)
            $display("FAIL midrst_full: rsp_valid=%b want 1", bus.rsp_valid);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 1'b1, 32'h1111_1111, 5'd2, 2'b01);
        set_req(1, 1'b1, 32'h2222_2222, 5'd2, 2'b01);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b00)
            $display("FAIL midrst_no_grant: req_ready=%b want 00", bus.req_ready);
        else
            n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0)
            $display("FAIL midrst_cleared: valid=%b data=%h id=%0d want 0/0/0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id);
        else
            n_pass++;
        sb_q.delete();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01)
            $display("FAIL midrst_ptr: req_ready=%b want 01", bus.req_ready);
        else
            n_pass++;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v   = '0;
        logic [NREQ-1:0] acc = '0;
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(v[i] && !acc[i])) begin
                    v[i] = ($urandom_range(0, 9) < 7);
                    set_req(i, v[i], N'($urandom), S'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.req_valid & bus.req_ready;
            @(negedge clk);
        end
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
        bus.rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0 || bus.rsp_valid !== 1'b0)
            $display("FAIL rand_drain: %0d responses outstanding, rsp_valid=%b want 0/0",
                     sb_q.size(), bus.rsp_valid);
        else
            n_pass++;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_shamt = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational `sll` barrel shifter between `NREQ` requesters (e.g. ALU shift path and load/store byte-alignment path) using a round-robin valid/ready arbiter. It implements SLL, SRL and SRA on the single left shifter by operand bit-reversal and sign-fill masking. Each accepted request produces one registered response tagged with the requester index. The block sits between execute-stage requesters and the shared shifter resource.

## Interface
- `N`, 32: data width; power of two.
- `NREQ`, 2: number of requesters; ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; a transfer occurs when valid&ready.
- `req_data`  in  NREQ*N  operand, requester i at bits [i*N +: N].
- `req_shamt`  in  NREQ*$clog2(N)  shift amount, requester i at [i*S +: S], where S=$clog2(N).
- `req_op`  in  NREQ*2  op per requester: 00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  N  shift result.
- `rsp_id`  out  $clog2(NREQ) (min 1)  index of the requester that produced `rsp_data`.

## Operation
- Response register: `rsp_valid`, `rsp_data`, `rsp_id`. Two states: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- `can_accept = !rsp_valid || rsp_ready`. Grants are issued only when `can_accept` is high.
- Round-robin arbitration:
  - Priority pointer `ptr` selects the highest-priority index. Search order is ptr, ptr+1, …, wrapping at NREQ.
  - The first valid requester in that order is granted.
  - At most one `req_ready` bit is high per cycle. `req_ready` is combinational from `req_valid`, `ptr` and `can_accept`.
- On a grant to index g:
  - The result of (`req_data[g]`, `req_shamt[g]`, `req_op[g]`) is registered into `rsp_data`; `rsp_id` is set to g and `rsp_valid` to 1.
  - `ptr` is set to g+1 mod NREQ.
- No grant and `rsp_ready`=1: `rsp_valid` is cleared to 0.
- No grant and `rsp_ready`=0: all response outputs hold.
- Simultaneous response pop and new grant in one cycle: the new response replaces the old one and `rsp_valid` stays 1. Full throughput is one response per cycle.
- Shift arithmetic (all N bits, shamt 0..N-1, no modulo needed):
  - SLL: `sll(x, sh)`.
  - SRL: `rev(sll(rev(x), sh))`.
  - SRA: SRL result OR `mask`. `mask` = `~rev(sll(rev({N{1}}), sh))` when x[N-1]=1, and 0 otherwise.
  - shamt=0 returns x unchanged for every op.
- Requesters must hold data, shamt and op stable while valid is high and ready is low. The arbiter does not latch unaccepted requests.

## Timing
- Latency: request accepted at edge t → `rsp_valid`/`rsp_data` visible after edge t, usable at edge t+1.
- Reset (`rst_n`=0 at a rising edge):
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `ptr`=0.
  - `req_ready` is all-zero while `rst_n`=0.
- Reset asserted mid-transfer discards the pending response. The requester sees no grant in the reset cycle.
- Backpressure: while FULL and `rsp_ready`=0, `req_ready`=0 and `ptr` is frozen.
- Starvation bound: a continuously valid requester is granted within NREQ grants.

## Structure
- Package `shift_pkg`:
  - `shift_op_t` enum: SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10.
  - `localparam SHIFT_W = 32`.
  - Function `bit_reverse` for N-bit vectors.
- Sub-module `shift_core` (combinational): instantiates `sll` and implements the rev/mask logic. Ports: in, shamt, op → out.
- `shift_arbiter` contains the priority pointer, grant logic, input mux and response register.
- Grant logic: a double-width masked priority encoder over `{req_valid, req_valid}` rotated by `ptr`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all requesters valid → `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0; after release, first grant goes to index 0.
- Ops: req0 x=0x8000_00F0, shamt=4. SLL → 0x0000_0F00; SRL → 0x0800_000F; SRA → 0xF800_000F. shamt=0 with every op → 0x8000_00F0.
- Round-robin: both requesters valid every cycle with `rsp_ready`=1 → grants alternate 0,1,0,1; `rsp_id` follows the same sequence one cycle later; one response per cycle.
- Backpressure: FULL with `rsp_ready`=0 for 5 cycles → `req_ready`=0, `rsp_data`/`rsp_id` stable; next grant follows the round-robin order that was frozen.
- Mid-operation reset: assert `rst_n`=0 while `rsp_valid`=1 and `rsp_ready`=0 → next cycle `rsp_valid`=0, `ptr`=0.
- Random: 1000 iterations of random data, shamt 0..31 and op on both requesters with random `rsp_ready` → each response matches the `<<`, `>>`, `>>>` reference model for its `rsp_id`, with no lost or duplicated transactions.
